fetch_controller: RTL and testbench

//  Sequences reads of the combinational instruction ROM and buffers the results for decode.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_controller.sv | 91 +++++++++
 tb/tb_fetch_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch path: the {pc, instr} entry carried
// through the prefetch FIFO and the fetch FSM state encoding.
package fetch_pkg;

    localparam int ADDR_WIDTH  = 10;
    localparam int DATA_WIDTH  = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries. The head is read combinationally so a
// pushed entry is visible the cycle after it is written; flush beats push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  fetch_entry_t             wdata_i,
    output fetch_entry_t             rdata_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t      mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push_i && !pop_i)      count_d = count_q + CW'(1);
            else if (!push_i && pop_i) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; the output mux hides stale contents.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch front end: owns the fetch PC, drives the ROM address, and queues
// {pc, instr} pairs for decode. Redirect flushes the queue and reloads the PC.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = fetch_pkg::ADDR_WIDTH,
    parameter int                    DATA_WIDTH = fetch_pkg::DATA_WIDTH,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic                       redirect_i,
    input  logic [ADDR_WIDTH-1:0]      redirect_pc_i,
    output logic [ADDR_WIDTH-1:0]      imem_addr_o,
    input  logic [DATA_WIDTH-1:0]      imem_data_i,
    output logic                       instr_valid_o,
    output logic [DATA_WIDTH-1:0]      instr_o,
    output logic [ADDR_WIDTH-1:0]      instr_pc_o,
    input  logic                       instr_ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_FETCH = FETCH;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  pop, push, full;
    logic [CW-1:0]         count;
    fetch_entry_t          wr_entry;
    fetch_entry_t          head;

    assign full = (count == CW'(DEPTH));
    assign pop  = instr_valid_o && instr_ready_i;
    // Popping at full frees the slot this cycle, so fetch can keep streaming.
    assign push = (state_q == ST_FETCH) && !redirect_i && (!full || pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable_i)  state_d = ST_FETCH;
            ST_FETCH: if (!enable_i) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_i)
            pc_d = redirect_pc_i & ~ADDR_WIDTH'(INSTR_BYTES - 1);
        else if (push)
            pc_d = pc_q + ADDR_WIDTH'(INSTR_BYTES);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign wr_entry.pc    = pc_q;
    assign wr_entry.instr = imem_data_i;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (push),
        .pop_i   (pop && !redirect_i),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .valid_o (instr_valid_o),
        .count_o (count)
    );

    assign imem_addr_o = pc_q;
    assign instr_o     = head.instr;
    assign instr_pc_o  = head.pc;
    assign count_o     = count;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a cycle model queues expected entries
// as fetches are predicted; a monitor compares every handshake against them.
module tb_fetch_controller;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          enable_i = 1'b0;
    logic          redirect_i = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          ready = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic [2:0]    count;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return {6'h2A, a, 16'hBEEF};
    endfunction

    assign imem_data = rom(imem_addr);

    always #5 clk = ~clk;

    fetch_controller #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .RESET_PC   ('0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_ready_i (ready),
        .count_o       (count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
    } exp_t;

    exp_t          exp_q[$];
    bit            m_state = 1'b0;
    int            m_count = 0;
    logic [AW-1:0] m_pc = '0;

    // Monitor/model: evaluates just before each rising edge.
    always begin
        bit   m_pop, m_push;
        exp_t e;
        @(negedge clk);
        #4;
        if (rst_i) begin
            m_state = 1'b0;
            m_count = 0;
            m_pc    = '0;
            exp_q.delete();
        end else begin
            chk("sb_count", 32'(count), 32'(m_count));
            chk("sb_valid", 32'(instr_valid), 32'(m_count != 0));
            chk("sb_imem_addr", 32'(imem_addr), 32'(m_pc));
            m_pop = (m_count != 0) && ready;
            if (redirect_i) begin
                exp_q.delete();
                m_count = 0;
                m_pc    = redirect_pc & ~10'h3;
            end else begin
                if (m_pop && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_head_pc", 32'(instr_pc), 32'(e.pc));
                    chk("sb_head_instr", instr, e.instr);
                    $display("[TB] pop pc=0x%03h instr=0x%08h", instr_pc, instr);
                end
                m_push = m_state && ((m_count < DEPTH) || m_pop);
                if (m_push) begin
                    exp_q.push_back('{m_pc, rom(m_pc)});
                    m_pc = m_pc + 10'd4;
                end
                m_count = m_count + int'(m_push) - int'(m_pop);
            end
            m_state = enable_i;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        enable_i   = 1'b0;
        redirect_i = 1'b0;
        ready      = 1'b0;
        step(2);
        rst_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", 32'(instr_pc), 0);
        chk("rst_imem_addr", 32'(imem_addr), 0);
        rst_i = 1'b0;

        // Streaming with decode always ready.
        enable_i = 1'b1;
        ready    = 1'b1;
        step(1);
        chk("t1_not_yet_valid", 32'(instr_valid), 0);
        step(1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", 32'(instr_valid), 1);
            chk("t1_pc", 32'(instr_pc), 32'(4 * i));
            step(1);
        end

        // Back-pressure until full, then release.
        do_reset();
        enable_i = 1'b1;
        step(10);
        chk("t2_full_count", 32'(count), 4);
        chk("t2_addr_hold", 32'(imem_addr), 32'h10);
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid", 32'(instr_valid), 1);
            chk("t2_pc", 32'(instr_pc), 32'(4 * i));
            step(1);
        end

        // Redirect at count 3 with a simultaneous pop.
        do_reset();
        enable_i = 1'b1;
        step(4);
        chk("t3_count3", 32'(count), 3);
        redirect_i  = 1'b1;
        redirect_pc = 10'h103;
        ready       = 1'b1;
        step(1);
        redirect_i = 1'b0;
        chk("t3_flush_count", 32'(count), 0);
        chk("t3_flush_valid", 32'(instr_valid), 0);
        step(1);
        chk("t3_valid", 32'(instr_valid), 1);
        chk("t3_pc", 32'(instr_pc), 32'h100);
        chk("t3_instr", instr, rom(10'h100));
        chk("t3_addr", 32'(imem_addr), 32'h104);

        // PC wrap at the top of the address space.
        ready       = 1'b0;
        redirect_i  = 1'b1;
        redirect_pc = 10'h3FC;
        step(1);
        redirect_i = 1'b0;
        chk("t4_addr_3fc", 32'(imem_addr), 32'h3FC);
        step(1);
        chk("t4_addr_wrap", 32'(imem_addr), 0);
        chk("t4_pc", 32'(instr_pc), 32'h3FC);
        chk("t4_instr", instr, rom(10'h3FC));
        chk("t4_count", 32'(count), 1);

        // Disable at count 2, drain, redirect while idle.
        do_reset();
        enable_i = 1'b1;
        step(3);
        chk("t5_count2", 32'(count), 2);
        enable_i = 1'b0;
        step(1);
        chk("t5_last_push_count", 32'(count), 3);
        chk("t5_addr_c", 32'(imem_addr), 32'h0C);
        ready = 1'b1;
        step(3);
        chk("t5_drained_count", 32'(count), 0);
        chk("t5_drained_valid", 32'(instr_valid), 0);
        chk("t5_addr_hold", 32'(imem_addr), 32'h0C);
        step(2);
        chk("t5_addr_hold2", 32'(imem_addr), 32'h0C);
        redirect_i  = 1'b1;
        redirect_pc = 10'h201;
        step(1);
        redirect_i = 1'b0;
        chk("t5_idle_redirect_addr", 32'(imem_addr), 32'h200);
        step(3);
        chk("t5_idle_no_push", 32'(count), 0);
        chk("t5_idle_addr_hold", 32'(imem_addr), 32'h200);
        enable_i = 1'b1;
        step(1);
        chk("t5_enable_count", 32'(count), 0);
        step(1);
        chk("t5_enable_valid", 32'(instr_valid), 1);
        chk("t5_enable_pc", 32'(instr_pc), 32'h200);

        // Asynchronous reset between clock edges.
        step(3);
        @(posedge clk);
        #3;
        rst_i = 1'b1;
        #1;
        chk("t6_async_valid", 32'(instr_valid), 0);
        chk("t6_async_addr", 32'(imem_addr), 0);
        chk("t6_async_count", 32'(count), 0);
        @(negedge clk);
        step(1);
        rst_i = 1'b0;
        step(2);
        chk("t6_restart_valid", 32'(instr_valid), 1);
        chk("t6_restart_pc", 32'(instr_pc), 0);
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
